result_overlay: RTL and testbench

Parametrised overlay for the gesture-recognition result: a debounced result code selects one of NUM_ICONS icon images. The selected icon is fetched from an external icon ROM bank and composited over the live LCD pixel stream at a configurable screen position, with colour-key transparency. The block sits between the LCD pixel generator and the LCD driver. It replaces a fixed-geometry, switch-decoded display stage with frame-synchronous, debounced and pipeline-aligned behaviour.

---
 rtl/result_overlay.sv | 174 +++++++++++++++++
 tb/tb_result_overlay.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/result_overlay.sv
// Result overlay: debounced recognition code picks an icon, fetched from an external ROM and keyed over the LCD stream.
// Latency: 3 pixel clocks from pixel input to pixel_data, fixed, no bubbles.
// Backpressure: none; one pixel per clock in and out. Optional ring around the icon: define RESULT_BORDER_EN.
module result_overlay #(
  parameter int                DATA_W        = 24,
  parameter int                CODE_W        = 6,
  parameter int                NUM_ICONS     = 7,
  parameter int                SEL_W         = 3,
  parameter int                ICON_W        = 100,
  parameter int                ICON_H        = 100,
  parameter int                ICON_X        = 700,
  parameter int                ICON_Y        = 0,
  parameter int                ADDR_W        = 14,
  parameter int                STABLE_FRAMES = 3,
  parameter logic [DATA_W-1:0] KEY_COLOR     = 24'hFF00FF,
  parameter int                BORDER_W      = 2,
  parameter logic [DATA_W-1:0] BORDER_COLOR  = 24'hFFFFFF
) (
  input  logic              pixel_clk,
  input  logic              sys_rst_p,
  input  logic              overlay_en,
  input  logic [11:0]       pixel_xpos,
  input  logic [11:0]       pixel_ypos,
  input  logic [DATA_W-1:0] lcd_data,
  input  logic [CODE_W-1:0] sdata,
  output logic              rom_rd_en,
  output logic [SEL_W-1:0]  rom_sel,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_rdata,
  output logic [DATA_W-1:0] pixel_data,
  output logic [SEL_W-1:0]  shown_sel
);

  localparam logic [11:0]      X_LO     = 12'(ICON_X);
  localparam logic [11:0]      X_HI     = 12'(ICON_X + ICON_W);
  localparam logic [11:0]      Y_LO     = 12'(ICON_Y);
  localparam logic [11:0]      Y_HI     = 12'(ICON_Y + ICON_H);
  localparam logic [3:0]       STABLE_C = 4'(STABLE_FRAMES);
  localparam logic [SEL_W-1:0] NONE_SEL = SEL_W'(NUM_ICONS - 1);

  // frame-synchronous state
  logic              r_origin_d;
  logic              r_en_q;
  logic [SEL_W-1:0]  r_cand;
  logic [3:0]        r_cnt;
  logic [SEL_W-1:0]  r_shown;
  // pipeline
  logic              r_rd_en;
  logic [SEL_W-1:0]  r_sel;
  logic [ADDR_W-1:0] r_addr;
  logic              r_draw1, r_draw2;
  logic [DATA_W-1:0] r_lcd1, r_lcd2;
  logic [DATA_W-1:0] r_pix;

  logic              w_origin, w_fs, w_in_win, w_en_eff, w_draw0;
  logic [SEL_W-1:0]  w_map, w_shown_next, w_sel_eff;
  logic [3:0]        w_cnt_next;
  logic [11:0]       w_dx, w_dy;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_pix_next;

  assign w_origin = (pixel_xpos == 12'd0) && (pixel_ypos == 12'd0);
  assign w_fs     = w_origin && !r_origin_d;

  // Out-of-range codes all land on the "none" icon.
  assign w_map = (int'(sdata) < NUM_ICONS - 1) ? SEL_W'(sdata) : NONE_SEL;

  assign w_cnt_next   = (w_map != r_cand) ? 4'd1 :
                        (r_cnt == STABLE_C) ? r_cnt : r_cnt + 4'd1;
  assign w_shown_next = (w_cnt_next == STABLE_C) ? w_map : r_shown;

  // The fs pixel itself already uses the freshly latched enable and icon.
  assign w_en_eff  = w_fs ? overlay_en : r_en_q;
  assign w_sel_eff = w_fs ? w_shown_next : r_shown;

  assign w_in_win = (pixel_xpos >= X_LO) && (pixel_xpos < X_HI) &&
                    (pixel_ypos >= Y_LO) && (pixel_ypos < Y_HI);
  assign w_draw0  = w_in_win && w_en_eff;

  assign w_dx   = pixel_xpos - X_LO;
  assign w_dy   = pixel_ypos - Y_LO;
  assign w_addr = ADDR_W'(w_dy) * ADDR_W'(ICON_W) + ADDR_W'(w_dx);

`ifdef RESULT_BORDER_EN
  // Signed compares: the ring may extend past coordinate 0 when the icon sits at an edge.
  localparam logic signed [13:0] RX_LO = 14'(ICON_X - BORDER_W);
  localparam logic signed [13:0] RX_HI = 14'(ICON_X + ICON_W + BORDER_W);
  localparam logic signed [13:0] RY_LO = 14'(ICON_Y - BORDER_W);
  localparam logic signed [13:0] RY_HI = 14'(ICON_Y + ICON_H + BORDER_W);

  logic        r_ring1, r_ring2;
  logic        w_ring0;
  logic signed [13:0] w_xs, w_ys;

  assign w_xs    = $signed({2'b00, pixel_xpos});
  assign w_ys    = $signed({2'b00, pixel_ypos});
  assign w_ring0 = w_en_eff && !w_in_win &&
                   (w_xs >= RX_LO) && (w_xs < RX_HI) &&
                   (w_ys >= RY_LO) && (w_ys < RY_HI);

  // ring flag travels alongside the window flag
  always_ff @(posedge pixel_clk) begin
    if (sys_rst_p) begin
      r_ring1 <= 1'b0;
      r_ring2 <= 1'b0;
    end else begin
      r_ring1 <= w_ring0;
      r_ring2 <= r_ring1;
    end
  end

  // compositing: opaque icon pixel, else ring, else live pixel
  always_comb begin
    w_pix_next = r_lcd2;
    if (r_draw2 && (rom_rdata != KEY_COLOR)) w_pix_next = rom_rdata;
    else if (r_ring2)                         w_pix_next = BORDER_COLOR;
  end
`else
  // compositing: opaque icon pixel, else live pixel
  always_comb begin
    w_pix_next = r_lcd2;
    if (r_draw2 && (rom_rdata != KEY_COLOR)) w_pix_next = rom_rdata;
  end
`endif

  // frame-start edge detect, debounce and enable latch, all updated only at fs
  always_ff @(posedge pixel_clk) begin
    if (sys_rst_p) begin
      r_origin_d <= 1'b0;
      r_en_q     <= 1'b0;
      r_cand     <= NONE_SEL;
      r_cnt      <= 4'd0;
      r_shown    <= NONE_SEL;
    end else begin
      r_origin_d <= w_origin;
      if (w_fs) begin
        r_en_q  <= overlay_en;
        r_cand  <= w_map;
        r_cnt   <= w_cnt_next;
        r_shown <= w_shown_next;
      end
    end
  end

  // stages 0..2: ROM request, data alignment, composited output
  always_ff @(posedge pixel_clk) begin
    if (sys_rst_p) begin
      r_rd_en <= 1'b0;
      r_sel   <= NONE_SEL;
      r_addr  <= '0;
      r_draw1 <= 1'b0;
      r_draw2 <= 1'b0;
      r_lcd1  <= '0;
      r_lcd2  <= '0;
      r_pix   <= '0;
    end else begin
      r_rd_en <= w_draw0;
      r_sel   <= w_sel_eff;
      if (w_in_win) r_addr <= w_addr;
      r_draw1 <= w_draw0;
      r_draw2 <= r_draw1;
      r_lcd1  <= lcd_data;
      r_lcd2  <= r_lcd1;
      r_pix   <= w_pix_next;
    end
  end

  assign rom_rd_en  = r_rd_en;
  assign rom_sel    = r_sel;
  assign rom_addr   = r_addr;
  assign pixel_data = r_pix;
  assign shown_sel  = r_shown;

endmodule

// File: tb/tb_result_overlay.sv
// Directed bench for result_overlay with a synchronous icon ROM model.
// Pixels are driven and outputs sampled on the falling clock edge.
module tb_result_overlay;

  logic        clk = 1'b0;
  logic        sys_rst_p;
  logic        overlay_en;
  logic [11:0] pixel_xpos, pixel_ypos;
  logic [23:0] lcd_data;
  logic [5:0]  sdata;
  logic        rom_rd_en;
  logic [2:0]  rom_sel;
  logic [13:0] rom_addr;
  logic [23:0] rom_rdata;
  logic [23:0] pixel_data;
  logic [2:0]  shown_sel;

  int checks   = 0;
  int failures = 0;

  logic [23:0] q_exp [3];
  logic        q_chk [3];

  logic [5:0]  codes [6];
  logic [2:0]  exp_sh [6];

  always #5 clk = ~clk;

  result_overlay dut (
    .pixel_clk  (clk),
    .sys_rst_p  (sys_rst_p),
    .overlay_en (overlay_en),
    .pixel_xpos (pixel_xpos),
    .pixel_ypos (pixel_ypos),
    .lcd_data   (lcd_data),
    .sdata      (sdata),
    .rom_rd_en  (rom_rd_en),
    .rom_sel    (rom_sel),
    .rom_addr   (rom_addr),
    .rom_rdata  (rom_rdata),
    .pixel_data (pixel_data),
    .shown_sel  (shown_sel)
  );

  // Icon ROM: two addresses carry fixed colours for the key test, others encode sel/addr.
  function automatic logic [23:0] rom_model(input logic [2:0] s, input logic [13:0] a);
    if (a == 14'd1010) return 24'hFF00FF;
    if (a == 14'd1011) return 24'h123456;
    return {1'b0, s, 6'd0, a};
  endfunction

  always @(posedge clk) rom_rdata <= rom_model(rom_sel, rom_addr);

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp_v, $time);
    end
  endtask

  task automatic q_clear();
    for (int i = 0; i < 3; i++) begin
      q_chk[i] = 1'b0;
      q_exp[i] = '0;
    end
  endtask

  // Drive one pixel; the pixel driven three calls earlier is visible now.
  task automatic px(input logic [11:0] x, input logic [11:0] y, input logic [23:0] lcd,
                    input logic chk, input logic [23:0] exp_v);
    if (q_chk[2]) check("pixel", pixel_data, q_exp[2]);
    q_chk[2] = q_chk[1]; q_exp[2] = q_exp[1];
    q_chk[1] = q_chk[0]; q_exp[1] = q_exp[0];
    q_chk[0] = chk;      q_exp[0] = exp_v;
    pixel_xpos = x;
    pixel_ypos = y;
    lcd_data   = lcd;
    @(negedge clk);
  endtask

  task automatic idle3();
    for (int i = 0; i < 3; i++) px(12'd5, 12'd300, 24'h0, 1'b0, 24'h0);
  endtask

  task automatic frame();
    px(12'd0, 12'd0, 24'h0, 1'b0, 24'h0);
    px(12'd5, 12'd300, 24'h0, 1'b0, 24'h0);
  endtask

  task automatic do_reset();
    sys_rst_p  = 1'b1;
    pixel_xpos = 12'd5;
    pixel_ypos = 12'd300;
    lcd_data   = 24'h0;
    @(negedge clk);
    @(negedge clk);
    check("rst_pixel", pixel_data, 24'h0);
    check("rst_addr", 24'(rom_addr), 24'h0);
    check("rst_rd_en", 24'(rom_rd_en), 24'h0);
    check("rst_rom_sel", 24'(rom_sel), 24'd6);
    check("rst_shown", 24'(shown_sel), 24'd6);
    sys_rst_p = 1'b0;
    q_clear();
  endtask

  initial begin
    sys_rst_p  = 1'b1;
    overlay_en = 1'b0;
    pixel_xpos = 12'd5;
    pixel_ypos = 12'd300;
    lcd_data   = 24'h0;
    sdata      = 6'd0;
    q_clear();
    @(negedge clk);

    // basic fetch
    do_reset();
    overlay_en = 1'b1;
    sdata      = 6'd2;
    frame(); check("basic_shown1", 24'(shown_sel), 24'd6);
    frame(); check("basic_shown2", 24'(shown_sel), 24'd6);
    frame(); check("basic_shown3", 24'(shown_sel), 24'd2);
    px(12'd699, 12'd0, 24'h111111, 1'b1, 24'h111111);
    px(12'd700, 12'd0, 24'hAAAAAA, 1'b1, 24'h200000);
    check("addr_first", 24'(rom_addr), 24'd0);
    check("rom_sel_first", 24'(rom_sel), 24'd2);
    check("rd_en_in", 24'(rom_rd_en), 24'd1);
    px(12'd799, 12'd99, 24'hBBBBBB, 1'b1, 24'h20270F);
    check("addr_last", 24'(rom_addr), 24'd9999);
    px(12'd800, 12'd99, 24'hCCCCCC, 1'b1, 24'hCCCCCC);
    check("rd_en_out", 24'(rom_rd_en), 24'd0);
    check("addr_hold", 24'(rom_addr), 24'd9999);
    // colour key
    px(12'd710, 12'd10, 24'h0A0B0C, 1'b1, 24'h0A0B0C);
    px(12'd711, 12'd10, 24'h0D0E0F, 1'b1, 24'h123456);
    idle3();

    // debounce
    do_reset();
    overlay_en = 1'b1;
    codes  = '{6'd1, 6'd1, 6'd4, 6'd1, 6'd1, 6'd1};
    exp_sh = '{3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 3'd1};
    for (int i = 0; i < 6; i++) begin
      sdata = codes[i];
      frame();
      check("debounce_seq", 24'(shown_sel), 24'(exp_sh[i]));
    end
    sdata = 6'd9;
    frame(); check("code9_f1", 24'(shown_sel), 24'd1);
    frame(); check("code9_f2", 24'(shown_sel), 24'd1);
    frame(); check("code9_f3", 24'(shown_sel), 24'd6);

    // enable latch
    sdata = 6'd3;
    frame(); frame(); frame();
    check("en_shown", 24'(shown_sel), 24'd3);
    frame();
    px(12'd720, 12'd49, 24'h444444, 1'b1, 24'h301338);
    overlay_en = 1'b0;
    px(12'd720, 12'd50, 24'h454545, 1'b1, 24'h30139C);
    px(12'd720, 12'd99, 24'h464646, 1'b1, 24'h3026C0);
    check("en_still_rd", 24'(rom_rd_en), 24'd1);
    idle3();
    frame();
    px(12'd720, 12'd50, 24'h777777, 1'b1, 24'h777777);
    check("en_off_rd1", 24'(rom_rd_en), 24'd0);
    px(12'd700, 12'd0, 24'h888888, 1'b1, 24'h888888);
    check("en_off_rd2", 24'(rom_rd_en), 24'd0);
    idle3();

    // reset mid-frame
    overlay_en = 1'b1;
    frame();
    px(12'd718, 12'd40, 24'h101010, 1'b1, 24'h300FB2);
    px(12'd719, 12'd40, 24'h111111, 1'b0, 24'h0);
    sys_rst_p = 1'b1;
    px(12'd720, 12'd40, 24'h121212, 1'b0, 24'h0);
    sys_rst_p = 1'b0;
    check("midrst_pixel", pixel_data, 24'h0);
    check("midrst_shown", 24'(shown_sel), 24'd6);
    check("midrst_rd_en", 24'(rom_rd_en), 24'd0);
    check("midrst_rom_sel", 24'(rom_sel), 24'd6);
    q_clear();
    px(12'd721, 12'd40, 24'h555555, 1'b1, 24'h555555);
    px(12'd730, 12'd41, 24'h666666, 1'b1, 24'h666666);
    idle3();
    frame();
    check("postrst_shown1", 24'(shown_sel), 24'd6);
    px(12'd720, 12'd40, 24'h131313, 1'b1, 24'h600FB4);
    frame(); frame();
    check("postrst_shown3", 24'(shown_sel), 24'd3);
    px(12'd720, 12'd40, 24'h141414, 1'b1, 24'h300FB4);
    idle3();

    // border ring
    frame();
`ifdef RESULT_BORDER_EN
    px(12'd698, 12'd50, 24'h010203, 1'b1, 24'hFFFFFF);
    px(12'd699, 12'd101, 24'h040506, 1'b1, 24'hFFFFFF);
`else
    px(12'd698, 12'd50, 24'h010203, 1'b1, 24'h010203);
    px(12'd699, 12'd101, 24'h040506, 1'b1, 24'h040506);
`endif
    check("ring_no_rd", 24'(rom_rd_en), 24'd0);
    px(12'd697, 12'd50, 24'h070809, 1'b1, 24'h070809);
    idle3();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
